// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of the data memory.
// Optional misaligned-access trap: define DMEM_ARB_MISALIGN_CHECK_EN.
module dmem_arbiter #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32,
   parameter int NREQ_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   // Requester 0: pipeline MEM stage
   input  logic                  r0_valid,
   output logic                  r0_ready,
   input  logic                  r0_we,
   input  logic [DM_ADDRESS-1:0] r0_addr,
   input  logic [DATA_W-1:0]     r0_wdata,
   input  logic [2:0]            r0_funct3,
   output logic                  r0_rvalid,
   output logic [DATA_W-1:0]     r0_rdata,
   // Requester 1: debug/DMA port
   input  logic                  r1_valid,
   output logic                  r1_ready,
   input  logic                  r1_we,
   input  logic [DM_ADDRESS-1:0] r1_addr,
   input  logic [DATA_W-1:0]     r1_wdata,
   input  logic [2:0]            r1_funct3,
   output logic                  r1_rvalid,
   output logic [DATA_W-1:0]     r1_rdata,
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
   output logic                  r0_err,
   output logic                  r1_err,
`endif
   // Memory side
   output logic                  MemRead,
   output logic                  MemWrite,
   output logic [DM_ADDRESS-1:0] a,
   output logic [DATA_W-1:0]     wd,
   output logic [2:0]            Funct3,
   input  logic [DATA_W-1:0]     rd,
   output logic                  busy,
   output logic [1:0]            state_dbg
);

   // Handshake: a transfer happens in the cycle where rN_valid and rN_ready are
   // both high; ready is only ever raised in IDLE, so a requester must hold
   // valid and its fields stable until it sees ready.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RWAIT = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                state, next_state;
   logic [NREQ_BITS-1:0]  rr_last;
   logic [NREQ_BITS-1:0]  own_id;
   logic [NREQ_BITS-1:0]  gnt_id;
   logic                  own_we;
   logic                  gnt_any;
   logic                  mis;
   logic                  sel_we;
   logic [DM_ADDRESS-1:0] sel_addr;
   logic [DATA_W-1:0]     sel_wdata;
   logic [2:0]            sel_f3;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
   logic                  own_err;
`endif

   // Unsupported access types collapse to a word access; 100 (LBU) is load-only.
   function automatic logic [2:0] f3_filter(input logic [2:0] f, input logic we);
      logic [2:0] r;
      case (f)
         3'b000, 3'b001, 3'b010: r = f;
         3'b100:                 r = we ? 3'b010 : 3'b100;
         default:                r = 3'b010;
      endcase
      return r;
   endfunction

   // Arbitration and request selection
   always_comb begin
      gnt_any = (state == IDLE) && (r0_valid || r1_valid);
      gnt_id  = '0;
      if (r0_valid && r1_valid)
         gnt_id = ~rr_last;
      else if (r1_valid)
         gnt_id = NREQ_BITS'(1);
      sel_we    = gnt_id[0] ? r1_we    : r0_we;
      sel_addr  = gnt_id[0] ? r1_addr  : r0_addr;
      sel_wdata = gnt_id[0] ? r1_wdata : r0_wdata;
      sel_f3    = f3_filter(gnt_id[0] ? r1_funct3 : r0_funct3, sel_we);
   end

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
   always_comb begin
      mis = 1'b0;
      case (sel_f3)
         3'b010:  mis = |sel_addr[1:0];
         3'b001:  mis = sel_addr[0];
         default: mis = 1'b0;
      endcase
   end
`else
   assign mis = 1'b0;
`endif

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (gnt_any) next_state = mis ? RESP : ISSUE;
         ISSUE:   next_state = own_we ? IDLE : RWAIT;
         RWAIT:   next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign r0_ready  = gnt_any & ~gnt_id[0];
   assign r1_ready  = gnt_any &  gnt_id[0];
   assign r0_rvalid = (state == RESP) & ~own_id[0];
   assign r1_rvalid = (state == RESP) &  own_id[0];
   assign busy      = (state != IDLE);
   assign state_dbg = state;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
   assign r0_err    = r0_rvalid & own_err;
   assign r1_err    = r1_rvalid & own_err;
`endif

   // Bus fields are captured at grant so they appear registered during ISSUE
   // and simply hold afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rr_last  <= NREQ_BITS'(1);
         own_id   <= '0;
         own_we   <= 1'b0;
         MemRead  <= 1'b0;
         MemWrite <= 1'b0;
         a        <= '0;
         wd       <= '0;
         Funct3   <= 3'b000;
         r0_rdata <= '0;
         r1_rdata <= '0;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
         own_err  <= 1'b0;
`endif
      end else begin
         state    <= next_state;
         MemRead  <= 1'b0;
         MemWrite <= 1'b0;
         if (gnt_any) begin
            rr_last <= gnt_id;
            own_id  <= gnt_id;
            own_we  <= sel_we;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
            own_err <= mis;
`endif
            if (mis) begin
               if (gnt_id[0]) r1_rdata <= '0;
               else           r0_rdata <= '0;
            end else begin
               MemRead  <= ~sel_we;
               MemWrite <= sel_we;
               a        <= sel_addr;
               wd       <= sel_wdata;
               Funct3   <= sel_f3;
            end
         end
         // Memory data is valid the cycle after the MemRead strobe.
         if (state == RWAIT) begin
            if (own_id[0]) r1_rdata <= rd;
            else           r0_rdata <= rd;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed tables/sequences plus a
// randomized run against a transaction-level reference model.
module tb_dmem_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          r0_valid, r0_ready, r0_we, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic [2:0]    r0_funct3;
  logic          r1_valid, r1_ready, r1_we, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic [2:0]    r1_funct3;
  logic          MemRead, MemWrite, busy;
  logic [AW-1:0] a;
  logic [DW-1:0] wd;
  logic [DW-1:0] rd = '0;
  logic [2:0]    Funct3;
  logic [1:0]    state_dbg;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  logic          r0_err, r1_err;
`endif

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_funct3(r0_funct3), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_funct3(r1_funct3), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    .r0_err(r0_err), .r1_err(r1_err),
`endif
    .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3),
    .rd(rd), .busy(busy), .state_dbg(state_dbg)
  );

  // Memory emulator: one word per address, read data one cycle after MemRead.
  logic [DW-1:0] emem [0:511];
  always @(posedge clk) begin
    if (MemRead) rd <= emem[a];
    if (MemWrite) emem[a] <= wd;
  end

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [0:511];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic v, input logic we, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wdat, input logic [2:0] f3);
    if (id == 0) begin
      r0_valid = v; r0_we = we; r0_addr = ad; r0_wdata = wdat; r0_funct3 = f3;
    end else begin
      r1_valid = v; r1_we = we; r1_addr = ad; r1_wdata = wdat; r1_funct3 = f3;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, '0, '0, 3'b000);
    drive(1, 0, 0, '0, '0, 3'b000);
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int n = 0; n < 8 && !done; n++) begin
      step();
      if (!busy) done = 1;
    end
    if (!done) begin
      failures++;
      $display("FAIL %s: busy never dropped", name);
    end
  endtask

  // Memory access type the bus must carry for a given request.
  function automatic logic [2:0] exp_f3(input logic [2:0] f, input logic we);
    if (f == 3'b000 || f == 3'b001 || f == 3'b010) return f;
    if (f == 3'b100 && !we) return f;
    return 3'b010;
  endfunction

  typedef struct {
    logic       we;
    logic [2:0] f3;
    logic [8:0] addr;
    logic [2:0] f3_bus;
    logic       mrd;
    logic       mwr;
  } vec_t;
  vec_t tbl [10];

  // Random-phase model state
  int cyc, free_t, bus_due, rsp_due, rsp_id, g, last;
  logic rsp_err, b_we;
  logic [AW-1:0] last_a;
  logic [DW-1:0] last_wd, ref_rd0, ref_rd1;
  logic [2:0] last_f3;
  logic       pend [2];
  logic       p_we [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wd [2];
  logic [2:0] p_f3 [2];

  initial begin
    for (int i = 0; i < 512; i++) emem[i] = '0;
    tbl[0] = '{1'b1, 3'b000, 9'h040, 3'b000, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 3'b001, 9'h040, 3'b001, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 3'b010, 9'h040, 3'b010, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 3'b100, 9'h040, 3'b010, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 3'b111, 9'h040, 3'b010, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 3'b011, 9'h044, 3'b010, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 3'b100, 9'h048, 3'b100, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 3'b101, 9'h048, 3'b010, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 3'b110, 9'h04c, 3'b010, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 3'b000, 9'h1f0, 3'b000, 1'b1, 1'b0};

    // Reset state
    do_reset();
    #1;
    check("reset_state", state_dbg, 2'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_memread", MemRead, 1'b0);
    check("reset_memwrite", MemWrite, 1'b0);
    check("reset_r0_rdata", r0_rdata, '0);
    check("reset_r1_rdata", r1_rdata, '0);

    // r0 word load from 0x010
    emem[9'h010] = 32'hDEADBEEF;
    step(); drive(0, 1, 0, 9'h010, '0, 3'b010); #1;
    check("ld_r0_ready", r0_ready, 1'b1);
    check("ld_r1_ready", r1_ready, 1'b0);
    step(); drive(0, 0, 0, '0, '0, 3'b000); #1;
    check("ld_memread", MemRead, 1'b1);
    check("ld_memwrite", MemWrite, 1'b0);
    check("ld_a", a, 9'h010);
    check("ld_funct3", Funct3, 3'b010);
    step(); #1;
    check("ld_memread_once", MemRead, 1'b0);
    check("ld_busy", busy, 1'b1);
    check("ld_early_rvalid", r0_rvalid, 1'b0);
    step(); #1;
    check("ld_r0_rvalid", r0_rvalid, 1'b1);
    check("ld_r0_rdata", r0_rdata, 32'hDEADBEEF);
    check("ld_r1_rvalid", r1_rvalid, 1'b0);
    check("ld_r1_rdata", r1_rdata, '0);
    step(); #1;
    check("ld_rvalid_pulse", r0_rvalid, 1'b0);
    check("ld_idle", busy, 1'b0);

    // r1 byte store to 0x024
    drive(1, 1, 1, 9'h024, 32'h12345678, 3'b000); #1;
    check("st_r1_ready", r1_ready, 1'b1);
    step(); drive(1, 0, 0, '0, '0, 3'b000); #1;
    check("st_memwrite", MemWrite, 1'b1);
    check("st_memread", MemRead, 1'b0);
    check("st_a", a, 9'h024);
    check("st_wd", wd, 32'h12345678);
    check("st_funct3", Funct3, 3'b000);
    check("st_rvalid", r1_rvalid, 1'b0);
    step(); #1;
    check("st_memwrite_once", MemWrite, 1'b0);
    check("st_busy", busy, 1'b0);
    check("st_no_rvalid", r1_rvalid, 1'b0);
    check("st_r1_rdata", r1_rdata, '0);

    // Both requesters hold store requests: grants must alternate 0,1,0,1
    do_reset();
    drive(0, 1, 1, 9'h060, 32'hA0A0A0A0, 3'b010);
    drive(1, 1, 1, 9'h064, 32'hB1B1B1B1, 3'b010);
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_ready0", r0_ready, (k % 4) == 0);
      check("rr_ready1", r1_ready, (k % 4) == 2);
      check("rr_memwrite", MemWrite, (k % 2) == 1);
      if (k % 4 == 3) check("rr_a1", a, 9'h064);
      step();
    end
    drive(0, 0, 0, '0, '0, 3'b000);
    drive(1, 0, 0, '0, '0, 3'b000);
    wait_idle("rr_drain");

    // r1 load aborted by reset during RWAIT
    step(); drive(1, 1, 0, 9'h030, '0, 3'b010); #1;
    check("abort_r1_ready", r1_ready, 1'b1);
    step(); drive(1, 0, 0, '0, '0, 3'b000); #1;
    check("abort_memread", MemRead, 1'b1);
    step(); #1;
    check("abort_in_rwait", state_dbg, 2'd2);
    reset = 1'b1;
    step(); reset = 1'b0; #1;
    check("abort_state_idle", state_dbg, 2'd0);
    check("abort_memread_low", MemRead, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("abort_no_rvalid", r1_rvalid, 1'b0);
      step();
    end

    // Valid dropped while busy: that request is never granted
    drive(0, 1, 1, 9'h070, 32'h1, 3'b010); #1;
    check("drop_r0_ready", r0_ready, 1'b1);
    step(); drive(0, 0, 0, '0, '0, 3'b000); drive(1, 1, 1, 9'h074, 32'h2, 3'b010); #1;
    check("drop_r1_busy_ready", r1_ready, 1'b0);
    step(); drive(1, 0, 0, '0, '0, 3'b000); #1;
    check("drop_r1_ready", r1_ready, 1'b0);
    check("drop_state", busy, 1'b0);
    step(); #1;
    check("drop_no_write", MemWrite, 1'b0);

    // Funct3 filter table
    for (int i = 0; i < 10; i++) begin
      step(); drive(0, 1, tbl[i].we, tbl[i].addr, 32'hC0DE0000 + i, tbl[i].f3); #1;
      check("tbl_ready", r0_ready, 1'b1);
      step(); drive(0, 0, 0, '0, '0, 3'b000); #1;
      check("tbl_memread", MemRead, tbl[i].mrd);
      check("tbl_memwrite", MemWrite, tbl[i].mwr);
      check("tbl_funct3", Funct3, tbl[i].f3_bus);
      check("tbl_a", a, tbl[i].addr);
      wait_idle("tbl_drain");
    end

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    // Misaligned word load traps without a memory strobe
    step(); drive(0, 1, 0, 9'h002, '0, 3'b010); #1;
    check("mis_ready", r0_ready, 1'b1);
    step(); drive(0, 0, 0, '0, '0, 3'b000); #1;
    check("mis_memread", MemRead, 1'b0);
    check("mis_rvalid", r0_rvalid, 1'b1);
    check("mis_err", r0_err, 1'b1);
    check("mis_rdata", r0_rdata, '0);
    step(); #1;
    check("mis_idle", busy, 1'b0);
    check("mis_err_pulse", r0_err, 1'b0);
    // Halfword load at 0x002 is aligned
    emem[9'h002] = 32'h0000BEEF;
    drive(0, 1, 0, 9'h002, '0, 3'b001); #1;
    check("lh_ready", r0_ready, 1'b1);
    step(); drive(0, 0, 0, '0, '0, 3'b000); #1;
    check("lh_memread", MemRead, 1'b1);
    step(); step(); #1;
    check("lh_rvalid", r0_rvalid, 1'b1);
    check("lh_err", r0_err, 1'b0);
    check("lh_rdata", r0_rdata, 32'h0000BEEF);
`endif

    // Randomized traffic against the transaction-level model
    do_reset();
    for (int i = 0; i < 512; i++) begin
      ref_mem[i] = $urandom;
      emem[i] = ref_mem[i];
    end
    exp_q.delete();
    cyc = 0; free_t = 0; bus_due = -1; rsp_due = -1; rsp_id = 0; last = 1;
    rsp_err = 0; b_we = 0;
    last_a = '0; last_wd = '0; last_f3 = 3'b000; ref_rd0 = '0; ref_rd1 = '0;
    for (int i = 0; i < 2; i++) pend[i] = 0;
    for (int t = 0; t < 2500; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1; p_we[i] = 1'($urandom_range(0, 1));
          p_addr[i] = AW'($urandom_range(0, 511)); p_wd[i] = $urandom;
          p_f3[i] = 3'($urandom_range(0, 7));
        end else if (pend[i] && cyc < free_t && $urandom_range(0, 7) == 0) begin
          pend[i] = 0;
        end
        drive(i, pend[i], p_we[i], p_addr[i], p_wd[i], p_f3[i]);
      end
      #1;
      g = -1;
      if (cyc >= free_t) begin
        if (pend[0] && pend[1]) g = 1 - last;
        else if (pend[0]) g = 0;
        else if (pend[1]) g = 1;
      end
      check("rnd_ready0", r0_ready, g == 0);
      check("rnd_ready1", r1_ready, g == 1);
      check("rnd_busy", busy, cyc < free_t);
      check("rnd_memread", MemRead, bus_due == cyc && !b_we);
      check("rnd_memwrite", MemWrite, bus_due == cyc && b_we);
      check("rnd_a", a, last_a);
      check("rnd_wd", wd, last_wd);
      check("rnd_funct3", Funct3, last_f3);
      check("rnd_rvalid0", r0_rvalid, rsp_due == cyc && rsp_id == 0);
      check("rnd_rvalid1", r1_rvalid, rsp_due == cyc && rsp_id == 1);
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
      check("rnd_err0", r0_err, rsp_due == cyc && rsp_id == 0 && rsp_err);
      check("rnd_err1", r1_err, rsp_due == cyc && rsp_id == 1 && rsp_err);
`endif
      if (rsp_due == cyc && exp_q.size() > 0) begin
        if (rsp_id == 0) ref_rd0 = exp_q.pop_front();
        else             ref_rd1 = exp_q.pop_front();
      end
      check("rnd_rdata0", r0_rdata, ref_rd0);
      check("rnd_rdata1", r1_rdata, ref_rd1);
      if (g >= 0) begin
        logic [2:0] f;
        logic       m;
        last = g;
        f = exp_f3(p_f3[g], p_we[g]);
        m = 0;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
        m = (f == 3'b010 && p_addr[g][1:0] != 2'b00) || (f == 3'b001 && p_addr[g][0]);
`endif
        rsp_err = m;
        if (m) begin
          exp_q.push_back('0);
          rsp_id = g; rsp_due = cyc + 1; free_t = cyc + 2;
        end else begin
          bus_due = cyc + 1; b_we = p_we[g];
          last_a = p_addr[g]; last_wd = p_wd[g]; last_f3 = f;
          if (p_we[g]) begin
            ref_mem[p_addr[g]] = p_wd[g];
            free_t = cyc + 2;
          end else begin
            exp_q.push_back(ref_mem[p_addr[g]]);
            rsp_id = g; rsp_due = cyc + 3; free_t = cyc + 4;
          end
        end
        pend[g] = 0;
      end
      step();
      cyc++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
